vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator: the next generation of the team's fixed 640x480 sync generator. It derives its own pixel-enable tick from the system clock through a programmable divider, and supports any horizontal/vertical geometry and either sync polarity. It provides a run/hold control and emits line-start pulses, frame-start pulses and a frame counter. It sits between the board clock and the pixel/framebuffer logic, which consumes `x`, `y`, `video_on` and `p_tick`.

---
 rtl/vga_timing_gen_if.sv | 26 ++
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and pixel/framebuffer logic.
interface vga_timing_gen_if #(
    parameter int unsigned W    = 10,
    parameter int unsigned FC_W = 16
);
    logic            en;
    logic            p_tick;
    logic            hsync;
    logic            vsync;
    logic            video_on;
    logic [W-1:0]    x;
    logic [W-1:0]    y;
    logic            line_start;
    logic            frame_start;
    logic [FC_W-1:0] frame_count;

    modport master (
        input  en,
        output p_tick, hsync, vsync, video_on, x, y, line_start, frame_start, frame_count
    );

    modport slave (
        output en,
        input  p_tick, hsync, vsync, video_on, x, y, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with programmable pixel-clock divider,
// run/hold control, line/frame start pulses and a frame counter.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned W         = 10,
    parameter int unsigned FC_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    vga_timing_gen_if.master bus
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [W-1:0]     X_LAST   = W'(H_TOTAL - 1);
    localparam logic [W-1:0]     Y_LAST   = W'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [W-1:0]     x_q, x_d, y_q, y_d;
    logic             hs_q, hs_d, vs_q, vs_d, vo_q, vo_d;
    logic             ls_q, ls_d, fs_q, fs_d;
    logic [FC_W-1:0]  fc_q, fc_d;
    logic             tick_c;

    function automatic logic hsync_of(input logic [W-1:0] xv);
        logic act;
        act = (32'(xv) >= HS_START) && (32'(xv) < HS_END);
        return act ? HSYNC_POL : ~HSYNC_POL;
    endfunction

    function automatic logic vsync_of(input logic [W-1:0] yv);
        logic act;
        act = (32'(yv) >= VS_START) && (32'(yv) < VS_END);
        return act ? VSYNC_POL : ~VSYNC_POL;
    endfunction

    function automatic logic video_of(input logic [W-1:0] xv, input logic [W-1:0] yv);
        return (32'(xv) < H_ACTIVE) && (32'(yv) < V_ACTIVE);
    endfunction

    assign tick_c = bus.en && (div_q == DIV_LAST);

    // Next raster position; sync/video are decoded from the next position so they never lag x/y.
    always_comb begin
        div_d = div_q;
        x_d   = x_q;
        y_d   = y_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        vo_d  = vo_q;
        ls_d  = 1'b0;
        fs_d  = 1'b0;
        fc_d  = fc_q;
        if (bus.en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
        if (tick_c) begin
            if (x_q == X_LAST) begin
                x_d  = '0;
                ls_d = 1'b1;
                if (y_q == Y_LAST) begin
                    y_d  = '0;
                    fs_d = 1'b1;
                    fc_d = fc_q + FC_W'(1);
                end else begin
                    y_d = y_q + W'(1);
                end
            end else begin
                x_d = x_q + W'(1);
            end
            hs_d = hsync_of(x_d);
            vs_d = vsync_of(y_d);
            vo_d = video_of(x_d, y_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            hs_q  <= ~HSYNC_POL;
            vs_q  <= ~VSYNC_POL;
            vo_q  <= 1'b1;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
            fc_q  <= '0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            vo_q  <= vo_d;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
            fc_q  <= fc_d;
        end
    end

    assign bus.p_tick      = tick_c;
    assign bus.hsync       = hs_q;
    assign bus.vsync       = vs_q;
    assign bus.video_on    = vo_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.line_start  = ls_q;
    assign bus.frame_start = fs_q;
    assign bus.frame_count = fc_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: fixed checkpoint table, hand sequences and random run vs a reference model.
module tb_vga_timing_gen;
    localparam int H_T = 16;
    localparam int V_T = 8;

    logic clk;
    logic rst_r;
    logic en_r;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: enabled edges since reset, and whether the last edge was enabled.
    int n_act    = 0;
    bit last_act = 1'b0;

    vga_timing_gen_if #(.W(10), .FC_W(16)) bus0 ();
    vga_timing_gen_if #(.W(10), .FC_W(2))  bus1 ();

    assign bus0.en = en_r;
    assign bus1.en = en_r;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(2), .W(10), .FC_W(16)
    ) dut0 (
        .clk(clk), .reset_n(rst_r), .bus(bus0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CLK_DIV(1), .W(10), .FC_W(2)
    ) dut1 (
        .clk(clk), .reset_n(rst_r), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_r) begin
            n_act    <= 0;
            last_act <= 1'b0;
        end else if (en_r) begin
            n_act    <= n_act + 1;
            last_act <= 1'b1;
        end else begin
            last_act <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tg, input int cd, input bit hpol, input int fcw,
                             input logic pt, input logic hs, input logic vs, input logic vo,
                             input logic [9:0] xa, input logic [9:0] ya,
                             input logic ls, input logic fs, input logic [15:0] fc);
        int p, ex, ey, efc;
        bit tick_last, ehs_act;
        p         = n_act / cd;
        ex        = p % H_T;
        ey        = (p / H_T) % V_T;
        efc       = (p / (H_T * V_T)) % (1 << fcw);
        tick_last = last_act && ((n_act % cd) == 0);
        ehs_act   = (ex >= 10) && (ex < 13);
        chk({tg, ".p_tick"}, 32'(pt), 32'(en_r && ((n_act % cd) == cd - 1)));
        chk({tg, ".x"}, 32'(xa), 32'(ex));
        chk({tg, ".y"}, 32'(ya), 32'(ey));
        chk({tg, ".hsync"}, 32'(hs), 32'(hpol ? ehs_act : !ehs_act));
        chk({tg, ".vsync"}, 32'(vs), 32'(!((ey >= 5) && (ey < 7))));
        chk({tg, ".video_on"}, 32'(vo), 32'((ex < 8) && (ey < 4)));
        chk({tg, ".line_start"}, 32'(ls), 32'(tick_last && ex == 0));
        chk({tg, ".frame_start"}, 32'(fs), 32'(tick_last && ex == 0 && ey == 0));
        chk({tg, ".frame_count"}, 32'(fc), 32'(efc));
    endtask

    task automatic check_all();
        check_dut("d0", 2, 1'b0, 16, bus0.p_tick, bus0.hsync, bus0.vsync, bus0.video_on,
                  bus0.x, bus0.y, bus0.line_start, bus0.frame_start, bus0.frame_count);
        check_dut("d1", 1, 1'b1, 2, bus1.p_tick, bus1.hsync, bus1.vsync, bus1.video_on,
                  bus1.x, bus1.y, bus1.line_start, bus1.frame_start, {14'b0, bus1.frame_count});
    endtask

    task automatic step(input bit e, input bit r);
        en_r  = e;
        rst_r = r;
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int cnt);
        for (int i = 0; i < cnt; i++) step(1'b1, 1'b1);
    endtask

    typedef struct {
        int k;
        bit pt;
        int x;
        int y;
        bit hs;
        bit vs;
        bit vo;
        bit ls;
        bit fs;
        int fc;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int k;
        // k = enabled edges since reset, expectations for dut0 (CLK_DIV=2)
        vecs[0]  = '{k:0,   pt:0, x:0,  y:0, hs:1, vs:1, vo:1, ls:0, fs:0, fc:0};
        vecs[1]  = '{k:1,   pt:1, x:0,  y:0, hs:1, vs:1, vo:1, ls:0, fs:0, fc:0};
        vecs[2]  = '{k:2,   pt:0, x:1,  y:0, hs:1, vs:1, vo:1, ls:0, fs:0, fc:0};
        vecs[3]  = '{k:16,  pt:0, x:8,  y:0, hs:1, vs:1, vo:0, ls:0, fs:0, fc:0};
        vecs[4]  = '{k:20,  pt:0, x:10, y:0, hs:0, vs:1, vo:0, ls:0, fs:0, fc:0};
        vecs[5]  = '{k:25,  pt:1, x:12, y:0, hs:0, vs:1, vo:0, ls:0, fs:0, fc:0};
        vecs[6]  = '{k:26,  pt:0, x:13, y:0, hs:1, vs:1, vo:0, ls:0, fs:0, fc:0};
        vecs[7]  = '{k:32,  pt:0, x:0,  y:1, hs:1, vs:1, vo:1, ls:1, fs:0, fc:0};
        vecs[8]  = '{k:33,  pt:1, x:0,  y:1, hs:1, vs:1, vo:1, ls:0, fs:0, fc:0};
        vecs[9]  = '{k:160, pt:0, x:0,  y:5, hs:1, vs:0, vo:0, ls:1, fs:0, fc:0};
        vecs[10] = '{k:224, pt:0, x:0,  y:7, hs:1, vs:1, vo:0, ls:1, fs:0, fc:0};
        vecs[11] = '{k:256, pt:0, x:0,  y:0, hs:1, vs:1, vo:1, ls:1, fs:1, fc:1};

        en_r  = 1'b0;
        rst_r = 1'b0;
        @(negedge clk);

        // Checkpoint table from reset (en held high during reset: reset must win)
        step(1'b1, 1'b0);
        k = 0;
        foreach (vecs[i]) begin
            while (k < vecs[i].k) begin
                step(1'b1, 1'b1);
                k++;
            end
            chk("tbl.p_tick", 32'(bus0.p_tick), 32'(vecs[i].pt));
            chk("tbl.x", 32'(bus0.x), 32'(vecs[i].x));
            chk("tbl.y", 32'(bus0.y), 32'(vecs[i].y));
            chk("tbl.hsync", 32'(bus0.hsync), 32'(vecs[i].hs));
            chk("tbl.vsync", 32'(bus0.vsync), 32'(vecs[i].vs));
            chk("tbl.video_on", 32'(bus0.video_on), 32'(vecs[i].vo));
            chk("tbl.line_start", 32'(bus0.line_start), 32'(vecs[i].ls));
            chk("tbl.frame_start", 32'(bus0.frame_start), 32'(vecs[i].fs));
            chk("tbl.frame_count", 32'(bus0.frame_count), 32'(vecs[i].fc));
        end

        // Hold at x=5 with div=0: resume needs two edges
        step(1'b1, 1'b0);
        run(10);
        chk("hold0.x_before", 32'(bus0.x), 32'd5);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1);
            chk("hold0.x", 32'(bus0.x), 32'd5);
            chk("hold0.p_tick", 32'(bus0.p_tick), 32'd0);
            chk("hold0.pulses", 32'({bus0.line_start, bus0.frame_start}), 32'd0);
        end
        step(1'b1, 1'b1);
        chk("hold0.resume1", 32'(bus0.x), 32'd5);
        step(1'b1, 1'b1);
        chk("hold0.resume2", 32'(bus0.x), 32'd6);

        // Hold with div held at 1: resume needs one edge
        step(1'b1, 1'b1);
        chk("hold1.p_tick_before", 32'(bus0.p_tick), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            chk("hold1.x", 32'(bus0.x), 32'd6);
        end
        step(1'b1, 1'b1);
        chk("hold1.resume", 32'(bus0.x), 32'd7);

        // Reset mid-frame at (9,3), then a full frame from release
        step(1'b1, 1'b0);
        run(114);
        chk("mid.x", 32'(bus0.x), 32'd9);
        chk("mid.y", 32'(bus0.y), 32'd3);
        step(1'b1, 1'b0);
        chk("mid.rst_xy", 32'({bus0.x, bus0.y}), 32'd0);
        chk("mid.rst_sync", 32'({bus0.hsync, bus0.vsync, bus0.video_on}), 32'b111);
        chk("mid.rst_pulses", 32'({bus0.line_start, bus0.frame_start, bus0.p_tick}), 32'd0);
        run(255);
        chk("mid.fs_early", 32'(bus0.frame_start), 32'd0);
        run(1);
        chk("mid.fs", 32'(bus0.frame_start), 32'd1);
        chk("mid.fc", 32'(bus0.frame_count), 32'd1);

        // CLK_DIV=1 / HSYNC_POL=1 / FC_W=2 variant
        step(1'b1, 1'b0);
        chk("var.p_tick_en", 32'(bus1.p_tick), 32'd1);
        run(10);
        chk("var.hsync_pos", 32'(bus1.hsync), 32'd1);
        chk("var.vsync", 32'(bus1.vsync), 32'd1);
        run(501);
        chk("var.fc3", 32'(bus1.frame_count), 32'd3);
        run(1);
        chk("var.fc_wrap", 32'(bus1.frame_count), 32'd0);
        chk("var.fs", 32'(bus1.frame_start), 32'd1);
        step(1'b0, 1'b1);
        chk("var.p_tick_off", 32'(bus1.p_tick), 32'd0);

        // Random run/hold/reset against the model
        step(1'b1, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 7) != 0, $urandom_range(0, 399) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
